inst_fetch_buffer: RTL and testbench
====================================

# inst_fetch_buffer

Instruction front-end that sits directly upstream of `topcontrol`. Receives the instruction program as a stream of narrow beats from the host/DMA side, assembles each `INST_LEN`-bit instruction, and queues it in a small FIFO. Presents the head instruction on `instruct`/`inst_empty` and pops it on `topcontrol`'s one-cycle `inst_req` pulse.

## Interface
Parameters:
- `INST_LEN`, 220, instruction width; bits [3:0] are the type code.
- `BEAT_W`, 32, input beat width.
- `DEPTH`, 16, FIFO entries; must be a power of two and at least 2.
- `BEATS`, derived, ceil(INST_LEN/BEAT_W) = 7 at the defaults.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  beat valid.
- `s_data`  in  BEAT_W  beat payload; least-significant beat first.
- `s_last`  in  1  marks the final beat of an instruction.
- `s_ready`  out  1  beat accepted when `s_valid && s_ready`.
- `instruct`  out  INST_LEN  head instruction.
- `inst_empty`  out  1  FIFO holds no complete instruction.
- `inst_req`  in  1  pops the head; ignored when `inst_empty`.
- `head_type`  out  4  `instruct[3:0]`.
- `level`  out  clog2(DEPTH)+1  number of stored instructions.
- `fetch_idle`  out  1  `inst_empty` and no partial instruction pending.
- `frame_err`  out  1  sticky error flag.
- `stat_popped`  out  32  statistics counter (see Configuration).
- `stat_full_cycles`  out  32  statistics counter (see Configuration).

## Operation
- Assembler: `beat_idx` counts 0..BEATS-1.
  - Each accepted beat writes `s_data` into slice `[beat_idx*BEAT_W +: BEAT_W]` of the `asm_reg` register.
  - Bits above `INST_LEN` in the final beat are discarded.
- On an accepted beat with `beat_idx==BEATS-1`:
  - The assembled word (with the final beat merged in) is written to the FIFO at `wr_ptr`.
  - `beat_idx` returns to 0.
- Framing:
  - `s_last` must be high exactly on beat BEATS-1.
  - `s_last` on an earlier beat: the partial instruction is discarded, `beat_idx` is set to 0, and `frame_err` is set.
  - `s_last` low on beat BEATS-1: the instruction is still written and `frame_err` is set.
  - `frame_err` is cleared only by reset.
- `s_ready = !full`, using the registered full flag. A push is never taken at full, even when a pop occurs in the same cycle.
- Pop: `inst_req && !inst_empty` advances `rd_ptr`. `inst_req` while empty has no effect.
- Pointers are clog2(DEPTH)+1 bits wide with natural wrap. Full when the MSBs differ and the lower bits are equal; empty when the pointers are equal.
- Simultaneous push and pop (not full, not empty): `level` is unchanged and both pointers advance.
- `instruct` is read combinationally from the storage entry at `rd_ptr`. Its value is don't-care while `inst_empty` is high.

## Timing
- Reset values:
  - `s_ready`=1, `inst_empty`=1, `fetch_idle`=1.
  - `level`=0, `frame_err`=0, stats=0.
  - `beat_idx`=0, pointers=0.
  - `instruct`/`head_type` are don't-care, since storage is not reset.
- Reset mid-instruction discards the partial instruction and all queued entries.
- Latency from final-beat acceptance to `inst_empty` low is 1 cycle. The new head is valid on `instruct` in that same cycle.
- Pop: `inst_req` sampled high at edge N means the next instruction (or `inst_empty`=1) is visible in cycle N+1. This matches `topcontrol` holding `inst_req` for exactly one cycle.
- Full: `s_ready` goes low in the cycle after the push that fills the FIFO. It returns high in the cycle after the first pop.
- Maximum throughput is one instruction per BEATS cycles.

## Configuration
- `INST_FETCH_STATS_EN` defined:
  - `stat_popped` increments on every accepted pop.
  - `stat_full_cycles` increments on every cycle with full=1.
  - Both counters saturate at 0xFFFF_FFFF and are reset to 0.
- Not defined: both ports are driven to constant 0 and no counter logic is generated.

## Structure
- `inst_fetch_pkg` holds:
  - type codes `INST_COMPUTE`=0, `INST_LD_WEIGHT`=1, `INST_LD_BIAS`=2, `INST_LD_DATA`=3, `INST_WR_DATA`=4;
  - a `beats_per_inst(INST_LEN, BEAT_W)` function.
- One sub-module, `inst_fifo_mem`: DEPTH×INST_LEN register array with a synchronous write port and an asynchronous read port.
- Pointer, assembler and statistics logic stay in `inst_fetch_buffer`.

## Test plan
- **Single instruction:** 7 beats with `s_last` on beat 6, encoding type=1 and payload 0xA5 in bits [27:4]. Required:
  - `inst_empty` falls 1 cycle after beat 6 is accepted;
  - `head_type`=1;
  - `instruct` equals the reassembled 220-bit word.
- **Fill to full:** push 16 instructions with no pops. Required:
  - `level`=16 and `s_ready`=0;
  - the 17th instruction's first beat is held.
  - Then pulse `inst_req` once: `s_ready`=1 the next cycle and `level`=15.
- **Concurrent push/pop:** with `level`=3, the final beat is accepted in the same cycle as `inst_req`. Required: `level` stays 3 and the FIFO order is preserved.
- **Wrap-around:** push and pop 40 instructions with incrementing payloads. Required: every popped word matches in order and `inst_empty`=1 at the end.
- **Framing error and empty pop:**
  - `s_last` on beat 3: `frame_err`=1, no FIFO write, and the next 7 beats form a valid instruction.
  - `inst_req` while empty: `level` stays 0.
- **Reset mid-instruction:** `rst_n` low after beat 4 with `level`=2. Required after reset: `level`=0, `inst_empty`=1, `fetch_idle`=1, and a fresh 7-beat instruction is assembled correctly.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch front-end.
// Holds the instruction type codes and the beats-per-instruction helper.
// No ports; import with inst_fetch_pkg::*.
package inst_fetch_pkg;

  typedef enum logic [3:0] {
    INST_COMPUTE   = 4'd0,
    INST_LD_WEIGHT = 4'd1,
    INST_LD_BIAS   = 4'd2,
    INST_LD_DATA   = 4'd3,
    INST_WR_DATA   = 4'd4
  } inst_type_e;

  // Number of input beats needed to carry one instruction (ceiling division).
  function automatic int beats_per_inst(input int inst_len, input int beat_w);
    return (inst_len + beat_w - 1) / beat_w;
  endfunction

endpackage

// File: rtl/inst_fifo_mem.sv
// Instruction FIFO storage: DEPTH x WIDTH register array, no reset.
// Latency: write lands at the clock edge; read is combinational from raddr.
// Backpressure: none here; the caller guarantees we is never asserted when full.
// Ports: clk, we/waddr/wdata (sync write), raddr/rdata (async read).
module inst_fifo_mem #(
  parameter int WIDTH = 220,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Assembles INST_LEN-bit instructions from BEAT_W beats (LSB beat first) and queues them for topcontrol.
// Latency: head visible 1 cycle after the final beat is accepted; a pop shows the next head 1 cycle later.
// Backpressure: s_ready = !full (registered pointers); a push is never taken at full, even with a same-cycle pop.
// Ports: s_valid/s_data/s_last/s_ready beat input; instruct/head_type/inst_empty/inst_req head + pop;
//        level, fetch_idle, frame_err (sticky) status; stat_popped/stat_full_cycles counters.
// Optional: define INST_FETCH_STATS_EN to build the saturating statistics counters (otherwise they read 0).
module inst_fetch_buffer
  import inst_fetch_pkg::*;
#(
  parameter int INST_LEN = 220,
  parameter int BEAT_W   = 32,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [BEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [INST_LEN-1:0]      instruct,
  output logic                     inst_empty,
  input  logic                     inst_req,
  output logic [3:0]               head_type,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     fetch_idle,
  output logic                     frame_err,
  output logic [31:0]              stat_popped,
  output logic [31:0]              stat_full_cycles
);

  localparam int BEATS = beats_per_inst(INST_LEN, BEAT_W);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int BIW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BIW-1:0] LAST_IDX = BIW'(BEATS - 1);

  logic [BIW-1:0]      beat_idx;
  logic [INST_LEN-1:0] asm_reg;
  logic [INST_LEN-1:0] asm_next;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                full;
  logic                empty;
  logic                beat_acc;
  logic                last_beat;
  logic                push;
  logic                pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_ready   = !full;
  assign beat_acc  = s_valid && s_ready;
  assign last_beat = (beat_idx == LAST_IDX);
  assign push      = beat_acc && last_beat;
  assign pop       = inst_req && !empty;

  // Merge the current beat into the assembly word bit by bit; bits of the
  // final beat that land above INST_LEN simply have no destination.
  always_comb begin
    asm_next = asm_reg;
    for (int i = 0; i < INST_LEN; i++) begin
      if (beat_idx == BIW'(i / BEAT_W)) asm_next[i] = s_data[i % BEAT_W];
    end
  end

  // Datapath register: every bit is rewritten before it is consumed, so no reset.
  always_ff @(posedge clk) begin
    if (beat_acc) asm_reg <= asm_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_idx  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
    end else begin
      if (beat_acc) begin
        if (last_beat) begin
          // Final beat is always written; a missing s_last only flags the error.
          beat_idx <= '0;
          if (!s_last) frame_err <= 1'b1;
        end else if (s_last) begin
          // Early s_last: drop the partial instruction and resynchronise.
          beat_idx  <= '0;
          frame_err <= 1'b1;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  inst_fifo_mem #(
    .WIDTH (INST_LEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (asm_next),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (instruct)
  );

  assign inst_empty = empty;
  assign head_type  = instruct[3:0];
  assign level      = wr_ptr - rd_ptr;
  assign fetch_idle = empty && (beat_idx == '0);

`ifdef INST_FETCH_STATS_EN
  logic [31:0] popped_cnt;
  logic [31:0] full_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      popped_cnt <= '0;
      full_cnt   <= '0;
    end else begin
      if (pop && (popped_cnt != '1)) popped_cnt <= popped_cnt + 32'd1;
      if (full && (full_cnt != '1))  full_cnt   <= full_cnt + 32'd1;
    end
  end

  assign stat_popped      = popped_cnt;
  assign stat_full_cycles = full_cnt;
`else
  assign stat_popped      = '0;
  assign stat_full_cycles = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: beat assembly, fill/backpressure,
// concurrent push/pop, pointer wrap, framing errors and mid-instruction reset.
module tb_inst_fetch_buffer;
  import inst_fetch_pkg::*;

  localparam int INST_LEN = 220;
  localparam int BEAT_W   = 32;
  localparam int DEPTH    = 16;
  localparam int BEATS    = 7;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  s_valid;
  logic [BEAT_W-1:0]     s_data;
  logic                  s_last;
  logic                  s_ready;
  logic [INST_LEN-1:0]   instruct;
  logic                  inst_empty;
  logic                  inst_req;
  logic [3:0]            head_type;
  logic [4:0]            level;
  logic                  fetch_idle;
  logic                  frame_err;
  logic [31:0]           stat_popped;
  logic [31:0]           stat_full_cycles;

  always #5 clk = ~clk;

  inst_fetch_buffer #(
    .INST_LEN (INST_LEN),
    .BEAT_W   (BEAT_W),
    .DEPTH    (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_last           (s_last),
    .s_ready          (s_ready),
    .instruct         (instruct),
    .inst_empty       (inst_empty),
    .inst_req         (inst_req),
    .head_type        (head_type),
    .level            (level),
    .fetch_idle       (fetch_idle),
    .frame_err        (frame_err),
    .stat_popped      (stat_popped),
    .stat_full_cycles (stat_full_cycles)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pops_since_rst = 0;
  logic [INST_LEN-1:0] exp_q [$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [INST_LEN-1:0] mk(input logic [3:0] t, input logic [23:0] p);
    logic [INST_LEN-1:0] w;
    w          = '0;
    w[3:0]     = t;
    w[27:4]    = p;
    w[63:32]   = {8'hC3, p};
    w[127:96]  = 32'h5A5A_0000 ^ {8'h00, p};
    w[219:196] = ~p;
    return w;
  endfunction

  task automatic send_beat(input logic [BEAT_W-1:0] d, input logic l);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int c = 0; c < 200 && !done; c++) begin
      if (s_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) check("beat_timeout", 256'd0, 256'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // last_at selects the beat that carries s_last; nbeats limits how many beats go out.
  task automatic send_inst(input logic [INST_LEN-1:0] w, input int last_at, input int nbeats);
    logic [BEATS*BEAT_W-1:0] pad;
    pad = {{(BEATS*BEAT_W-INST_LEN){1'b0}}, w};
    for (int b = 0; b < nbeats; b++) send_beat(pad[b*BEAT_W +: BEAT_W], b == last_at);
  endtask

  task automatic push_inst(input logic [INST_LEN-1:0] w);
    send_inst(w, BEATS - 1, BEATS);
    exp_q.push_back(w);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() > 0) begin
      check(tag, instruct, exp_q[0]);
      void'(exp_q.pop_front());
    end
    inst_req = 1'b1;
    @(posedge clk); #1;
    inst_req = 1'b0;
    pops_since_rst++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    inst_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    pops_since_rst = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [INST_LEN-1:0]     w;
    logic [BEATS*BEAT_W-1:0] pad;
    s_data = '0;
    do_reset();

    // Reset state
    check("rst_s_ready",    s_ready,          1);
    check("rst_inst_empty", inst_empty,       1);
    check("rst_fetch_idle", fetch_idle,       1);
    check("rst_level",      level,            0);
    check("rst_frame_err",  frame_err,        0);
    check("rst_stat_pop",   stat_popped,      0);
    check("rst_stat_full",  stat_full_cycles, 0);

    // Single instruction: type LD_WEIGHT, payload 0xA5
    w = mk(INST_LD_WEIGHT, 24'h0000A5);
    send_inst(w, BEATS - 1, BEATS - 1);
    check("single_partial_empty", inst_empty, 1);
    check("single_partial_idle",  fetch_idle, 0);
    pad = {4'b0, w};
    send_beat(pad[6*BEAT_W +: BEAT_W], 1'b1);
    check("single_empty_fall", inst_empty, 0);
    check("single_head_type",  head_type,  4'd1);
    check("single_level",      level,      1);
    exp_q.push_back(w);
    pop_check("single_word");
    check("single_after_pop_empty", inst_empty, 1);

    // Fill to full, hold the 17th instruction's first beat
    for (int i = 0; i < DEPTH; i++) push_inst(mk(INST_LD_BIAS, 24'h100 + 24'(i)));
    check("full_level",   level,   16);
    check("full_s_ready", s_ready, 0);
    w   = mk(INST_LD_DATA, 24'h777777);
    pad = {4'b0, w};
    s_valid = 1'b1;
    s_data  = pad[BEAT_W-1:0];
    s_last  = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("full_hold_ready", s_ready, 0);
    check("full_hold_level", level,   16);
    check("full_head",       instruct, exp_q[0]);
    void'(exp_q.pop_front());
    inst_req = 1'b1;
    @(posedge clk); #1;
    inst_req = 1'b0;
    pops_since_rst++;
    check("full_pop_ready", s_ready, 1);
    check("full_pop_level", level,   15);
    @(posedge clk); #1;   // held beat 0 accepted here
    s_valid = 1'b0;
    for (int b = 1; b < BEATS; b++) send_beat(pad[b*BEAT_W +: BEAT_W], b == BEATS - 1);
    exp_q.push_back(w);
    check("full_refill_level", level, 16);
    while (exp_q.size() > 0) pop_check("full_drain");
    check("full_drain_empty", inst_empty, 1);

    // Concurrent push/pop at level 3
    for (int i = 0; i < 3; i++) push_inst(mk(INST_WR_DATA, 24'h200 + 24'(i)));
    w   = mk(INST_COMPUTE, 24'h2FF);
    pad = {4'b0, w};
    for (int b = 0; b < BEATS - 1; b++) send_beat(pad[b*BEAT_W +: BEAT_W], 1'b0);
    check("conc_head", instruct, exp_q[0]);
    void'(exp_q.pop_front());
    s_valid  = 1'b1;
    s_data   = pad[6*BEAT_W +: BEAT_W];
    s_last   = 1'b1;
    inst_req = 1'b1;
    @(posedge clk); #1;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    inst_req = 1'b0;
    pops_since_rst++;
    exp_q.push_back(w);
    check("conc_level", level, 3);
    while (exp_q.size() > 0) pop_check("conc_order");

    // Wrap-around: 40 instructions with up to 3 queued
    for (int i = 0; i < 40; i++) begin
      push_inst(mk(INST_LD_DATA, 24'h300 + 24'(i)));
      if (exp_q.size() >= 3) pop_check("wrap_order");
    end
    while (exp_q.size() > 0) pop_check("wrap_drain");
    check("wrap_empty", inst_empty, 1);
    check("wrap_level", level,      0);
`ifdef INST_FETCH_STATS_EN
    check("stat_popped", stat_popped, pops_since_rst);
`else
    check("stat_popped", stat_popped, 0);
`endif

    // Framing error: s_last on beat 3
    check("frame_err_clear", frame_err, 0);
    send_inst(mk(INST_LD_BIAS, 24'hBAD), 3, 4);
    check("frame_err_set",    frame_err,  1);
    check("frame_no_write",   level,      0);
    check("frame_idle",       fetch_idle, 1);
    push_inst(mk(INST_LD_WEIGHT, 24'h400));
    check("frame_next_level", level, 1);
    pop_check("frame_next_word");

    // Pop while empty
    inst_req = 1'b1;
    @(posedge clk); #1;
    inst_req = 1'b0;
    check("empty_pop_level", level,      0);
    check("empty_pop_empty", inst_empty, 1);

    // Reset mid-instruction with two queued
    push_inst(mk(INST_COMPUTE, 24'h500));
    push_inst(mk(INST_COMPUTE, 24'h501));
    send_inst(mk(INST_COMPUTE, 24'h502), BEATS - 1, 5);
    check("prerst_level", level, 2);
    do_reset();
    check("midrst_level",     level,      0);
    check("midrst_empty",     inst_empty, 1);
    check("midrst_idle",      fetch_idle, 1);
    check("midrst_frame_err", frame_err,  0);
    check("midrst_ready",     s_ready,    1);
    push_inst(mk(INST_LD_DATA, 24'h600));
    check("midrst_level1",    level,      1);
    pop_check("midrst_word");

    // Missing s_last on the final beat: still written, error flagged
    send_inst(mk(INST_WR_DATA, 24'h700), BEATS, BEATS);
    exp_q.push_back(mk(INST_WR_DATA, 24'h700));
    check("nolast_frame_err", frame_err, 1);
    check("nolast_level",     level,     1);
    pop_check("nolast_word");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
